// File: rtl/parity_frame_checker_if.sv
// Handshake bundle for parity_frame_checker: beat input channel, result
// output channel and the error-counter sideband (ERR_CNT, CLR_CNT).
// master = producer/consumer side, slave = the checker.
interface parity_frame_checker_if #(
    parameter int DATA_W = 4,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 8
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] IN_DATA;
    logic              IN_LAST;
    logic              IN_PAR;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic              OUT_PAR;
    logic              OUT_ERR;
    logic [LEN_W-1:0]  OUT_LEN;
    logic [CNT_W-1:0]  ERR_CNT;
    logic              CLR_CNT;

    modport master (
        output IN_VALID, IN_DATA, IN_LAST, IN_PAR,
        output OUT_READY, CLR_CNT,
        input  IN_READY, OUT_VALID, OUT_PAR, OUT_ERR,
        input  OUT_LEN, ERR_CNT
    );

    modport slave (
        input  IN_VALID, IN_DATA, IN_LAST, IN_PAR,
        input  OUT_READY, CLR_CNT,
        output IN_READY, OUT_VALID, OUT_PAR, OUT_ERR,
        output OUT_LEN, ERR_CNT
    );
endinterface

// File: rtl/parity_frame_checker.sv
// Streaming frame parity checker: folds per-beat XOR parity over a frame
// ended by IN_LAST, compares with IN_PAR, holds the result on a
// valid/ready channel and keeps a saturating error counter.
// Ports: CP clock, CD sync active-low reset, bus (slave modport).
module parity_frame_checker #(
    parameter int DATA_W = 4,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 8,
    parameter int ODD    = 0
) (
    input logic                   CP,
    input logic                   CD,
    parity_frame_checker_if.slave bus
);
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic ODD_B = (ODD != 0);

    state_t             state_q;
    state_t             state_d;
    logic               acc_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               par_q;
    logic               err_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   err_cnt_q;

    logic               in_ready;
    logic               out_valid;
    logic               accept;
    logic               bp;
    logic               p;
    logic               mismatch;
    logic [LEN_W-1:0]   cnt_inc;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (bus.IN_VALID && bus.IN_LAST)
                    state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (bus.OUT_READY)
                    state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    assign accept   = bus.IN_VALID && in_ready;
    assign bp       = ^bus.IN_DATA;
    assign p        = acc_q ^ bp ^ ODD_B;
    assign mismatch = (p != bus.IN_PAR);
    // Count saturates at all-ones; parity keeps folding regardless.
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);

    always_ff @(posedge CP) begin
        if (!CD) begin
            state_q   <= ACCUM;
            acc_q     <= 1'b0;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            err_q     <= 1'b0;
            len_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (bus.IN_LAST) begin
                    par_q <= p;
                    err_q <= mismatch;
                    len_q <= cnt_inc;
                    acc_q <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= acc_q ^ bp;
                    cnt_q <= cnt_inc;
                end
            end
            // Clear beats a coincident increment.
            if (bus.CLR_CNT)
                err_cnt_q <= '0;
            else if (accept && bus.IN_LAST && mismatch
                     && err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_PAR   = par_q;
    assign bus.OUT_ERR   = err_q;
    assign bus.OUT_LEN   = len_q;
    assign bus.ERR_CNT   = err_cnt_q;
endmodule
